// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   * mdu_op_e    : 3-bit MDU operation encoding driven by the E stage
//   * mdu_state_e : controller FSM states
//   * MUL_CYCLES_DEFAULT / DIV_CYCLES_DEFAULT : default execute latencies
// Optional feature macro: MDU_MADD_EN (enables MADD/MSUB accumulate ops).
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MUL_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if -- pipeline <-> MDU connection.
//   master (pipeline): drives start, op, src_a, src_b; receives busy, hi, lo
//   slave  (MDU)     : receives start, op, src_a, src_b; drives busy, hi, lo
// -----------------------------------------------------------------------------
interface mdu_if;
    import mdu_pkg::*;

    logic        start;  // E-stage MDU instruction valid and not stalled
    mdu_op_e     op;
    logic [31:0] src_a;  // forwarded rs
    logic [31:0] src_b;  // forwarded rt
    logic        busy;   // unit executing; feeds hazard stall logic
    logic [31:0] hi;     // architectural HI
    logic [31:0] lo;     // architectural LO

    modport master (output start, op, src_a, src_b, input  busy, hi, lo);
    modport slave  (input  start, op, src_a, src_b, output busy, hi, lo);

endinterface

// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core -- purely combinational MDU datapath.
//   op, src_a, src_b : latched operation and operands
//   hi, lo           : current architectural HI/LO (accumulate source)
//   result           : 64-bit {hi, lo} value to write when the op retires
// Optional feature macro: MDU_MADD_EN (adds the MADD/MSUB accumulate path).
// -----------------------------------------------------------------------------
module mdu_core
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of the extended operands' product are exact in both cases.
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide goes through magnitudes: this truncates toward zero, gives
    // the remainder the dividend's sign, and makes 0x80000000 / -1 wrap to
    // 0x80000000 with remainder 0 without a special case.
    assign signed_div = (op == OP_DIV);
    assign neg_a      = signed_div & src_a[31];
    assign neg_b      = signed_div & src_b[31];
    assign mag_a      = neg_a ? -src_a : src_a;
    assign mag_b      = neg_b ? -src_b : src_b;
    assign div_zero   = (src_b == 32'd0);
    assign q_mag      = div_zero ? 32'd0 : mag_a / mag_b;
    assign r_mag      = div_zero ? 32'd0 : mag_a % mag_b;
    assign quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem        = neg_a ? -r_mag : r_mag;

    always_comb begin
        // NOTE: every path assigns result (default first), so no latch is inferred.
        result = {hi, lo};
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                if (div_zero) result = {src_a, 32'hFFFF_FFFF};
                else          result = {rem, quot};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MSUB:  result = {hi, lo} - prod_s;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multi-cycle MDU controller: FSM, latency counter, HI/LO.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mdu_if.slave (start/op/src_a/src_b in; busy/hi/lo out)
// Parameters: MUL_CYCLES (MULT/MULTU/MADD/MSUB), DIV_CYCLES (DIV/DIVU).
// Optional feature macro: MDU_MADD_EN -- ops 6/7 accumulate into HI/LO;
// without it they are no-ops.
// A start seen while RUN is ignored; the hazard unit must never issue one.
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
)(
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    mdu_op_e            op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               latch_en;
    logic               long_op;
    logic [CNT_W-1:0]   load_cnt;
    logic [63:0]        result;

    // Classify the incoming op: which ops launch a multi-cycle run, and for how long.
    always_comb begin
        long_op  = 1'b0;
        load_cnt = '0;
        case (bus.op)
            OP_MULT, OP_MULTU: begin
                long_op  = 1'b1;
                load_cnt = CNT_W'(MUL_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                long_op  = 1'b1;
                load_cnt = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
                long_op  = 1'b1;
                load_cnt = CNT_W'(MUL_CYCLES);
            end
`endif
            default: ;
        endcase
    end

    // HI/LO cannot change while RUN (MTHI/MTLO are only honoured in IDLE),
    // so the live registers equal their values at the start edge.
    mdu_core u_core (
        .op     (op_q),
        .src_a  (a_q),
        .src_b  (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MTHI) begin
                        hi_d = bus.src_a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.src_a;
                    end else if (long_op) begin
                        state_d  = RUN;
                        cnt_d    = load_cnt;
                        latch_en = 1'b1;
                    end
                end
            end
            RUN: begin
                // Retire on the edge where the counter reads 1, so busy is
                // high for exactly the loaded number of cycles.
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    {hi_d, lo_d} = result;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand latches are datapath only, consumed solely in RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            op_q <= bus.op;
            a_q  <= bus.src_a;
            b_q  <= bus.src_b;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl (default latencies 5/10).
// Directed vectors for the documented cases plus randomized op streams,
// compared against a behavioural HI/LO model. Honours MDU_MADD_EN.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit madd_on();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: updates m_hi/m_lo with plain 64-bit arithmetic and
    // reports whether the op should occupy the unit and for how long.
    task automatic model(input int op, input logic [31:0] a, input logic [31:0] b,
                         output bit long_op, output int cycles);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] acc;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        long_op = 1'b0;
        cycles  = 0;
        case (op)
            0: begin
                acc = 64'(sa * sb);
                {m_hi, m_lo} = acc;
                long_op = 1'b1; cycles = MUL_N;
            end
            1: begin
                acc = 64'(a) * 64'(b);
                {m_hi, m_lo} = acc;
                long_op = 1'b1; cycles = MUL_N;
            end
            2, 3: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (op == 2) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                long_op = 1'b1; cycles = DIV_N;
            end
            4: m_hi = a;
            5: m_lo = a;
            default: begin
                if (madd_on()) begin
                    acc = {m_hi, m_lo};
                    if (op == 6) acc = acc + 64'(sa * sb);
                    else         acc = acc - 64'(sa * sb);
                    {m_hi, m_lo} = acc;
                    long_op = 1'b1; cycles = MUL_N;
                end
            end
        endcase
    endtask

    // Issue one op at a negedge, then check latency and the resulting HI/LO.
    task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        bit long_op;
        int cyc;
        int cnt;
        model(op, a, b, long_op, cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = mdu_op_e'(3'(op));
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        if (long_op) begin
            cnt = 0;
            while (bus.busy === 1'b1 && cnt < 200) begin
                cnt++;
                @(negedge clk);
            end
            check({tag, "/busy_cycles"}, 64'(cnt), 64'(cyc));
        end else begin
            check({tag, "/busy_low"}, 64'(bus.busy), 64'd0);
            @(negedge clk);
            check({tag, "/busy_low2"}, 64'(bus.busy), 64'd0);
        end
        check({tag, "/hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, "/lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        int cnt;
        int op;
        logic [31:0] a;
        logic [31:0] b;

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        reset     = 1'b0;
        m_hi      = '0;
        m_lo      = '0;

        #1;
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/hi",   64'(bus.hi),   64'd0);
        check("reset/lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Documented vectors.
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
        check("mult/hi_lit", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("mult/lo_lit", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
        check("multu/hi_lit", 64'(bus.hi), 64'h1);
        check("multu/lo_lit", 64'(bus.lo), 64'hFFFF_FFFE);
        do_op(2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        check("div_neg/lo_lit", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg/hi_lit", 64'(bus.hi), 64'hFFFF_FFFF);
        do_op(3, 32'd5, 32'd0, "divu_zero");
        check("divu_zero/hi_lit", 64'(bus.hi), 64'h5);
        check("divu_zero/lo_lit", 64'(bus.lo), 64'hFFFF_FFFF);
        do_op(2, 32'd7, 32'd0, "div_zero");
        do_op(2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf/lo_lit", 64'(bus.lo), 64'h8000_0000);
        check("div_ovf/hi_lit", 64'(bus.hi), 64'h0);

        do_op(5, 32'd5, 32'hDEAD_BEEF, "mtlo");
        do_op(4, 32'd0, 32'hDEAD_BEEF, "mthi");
        do_op(6, 32'd3, 32'd4, "madd");
        if (madd_on()) check("madd/lo_lit", 64'(bus.lo), 64'h11);
        else           check("madd/lo_lit", 64'(bus.lo), 64'h5);
        check("madd/hi_lit", 64'(bus.hi), 64'h0);
        do_op(7, 32'hFFFF_FFFD, 32'd4, "msub");

        // Start pulsed while busy must be ignored; DIV result and latency stand.
        do_op(4, 32'h1234_5678, 32'd0, "pre_mthi");
        model(2, 32'd100, 32'd7, op[0], cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 2) begin
                $display("note: start asserted while busy at %0t (hazard violation, must be ignored)", $time);
                bus.start = 1'b1; bus.op = OP_MULT;
                bus.src_a = 32'h0000_0003; bus.src_b = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_start/cycles", 64'(cnt), 64'(DIV_N));
        check("busy_start/hi", 64'(bus.hi), 64'(m_hi));
        check("busy_start/lo", 64'(bus.lo), 64'(m_lo));
        @(negedge clk);
        check("busy_start/no_relaunch", 64'(bus.busy), 64'd0);

        // Asynchronous reset during the 3rd RUN cycle of a DIV.
        do_op(5, 32'hCAFE_F00D, 32'd0, "pre_mtlo");
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(negedge clk);          // 1st RUN cycle
        bus.start = 1'b0;
        @(negedge clk);          // 2nd
        @(negedge clk);          // 3rd
        #1 reset = 1'b0;
        #1;
        check("midrun_rst/busy", 64'(bus.busy), 64'd0);
        check("midrun_rst/hi",   64'(bus.hi),   64'd0);
        check("midrun_rst/lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < DIV_N; i++) @(negedge clk);
        check("post_rst/busy", 64'(bus.busy), 64'd0);
        check("post_rst/hi",   64'(bus.hi),   64'd0);
        check("post_rst/lo",   64'(bus.lo),   64'd0);

        // Randomized op stream.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            do_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
